// File: rtl/z80_alu16_seq.sv
// ---------------------------------------------------------------------------
// z80_alu16_seq
//
// Multi-cycle sequencer for the Z80 16-bit ADD / ADC / SBC on register pairs.
// One 8-bit adder is used twice (low byte, then high byte). The carry is
// chained between the two passes. The operation is then padded so that `done`
// always lands exactly LATENCY clocks after the accepting edge. This matches
// the M-cycle timing of ADD HL/IX/IY,ss, ADC HL,ss and SBC HL,ss.
//
// Parameters
//   LATENCY   clocks from accept to done, legal range 2..15
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   start     in   request, accepted when idle or in the completion cycle
//   op        in   00 ADD, 01 ADC, 10 SBC, 11 illegal
//   operand1  in   destination pair value (HL/IX/IY)
//   operand2  in   source pair value
//   f_in      in   current F, {S,Z,5,H,3,PV,N,C}
//   busy      out  operation in flight
//   done      out  one-cycle completion pulse
//   illegal   out  pulses with done when op=11
//   result    out  16-bit result, held until the next completion
//   f_out     out  new F, held until the next completion
// ---------------------------------------------------------------------------
module z80_alu16_seq #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] operand1,
  input  logic [15:0] operand2,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] result,
  output logic [7:0]  f_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    PAD  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SBC = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // The counter value on the cycle whose closing edge completes the operation.
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  // Control state.
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Operation latched at accept.
  // b holds the effective addend, already inverted for SBC.
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic [7:0]  fin_q, fin_d;

  // Results of the low and high adder passes.
  logic [7:0]  lo_q, lo_d;
  logic        c7_q, c7_d;
  logic [7:0]  hi_q, hi_d;
  logic        h_q, h_d;
  logic        c_q, c_d;
  logic        v_q, v_d;

  // Registered outputs.
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  fout_q, fout_d;

  // Shared adder, low pass and high pass.
  logic [8:0]  lo_sum;
  logic [8:0]  hi_sum;
  logic        h_now, c_now, v_now;

  // Final high byte and carries, selected from the live pass or the registered pass.
  logic [7:0]  hi_fin;
  logic        h_fin, c_fin, v_fin;
  logic [15:0] r_fin;
  logic [7:0]  flags_fin;
  logic [15:0] res_fin;
  logic        complete;
  logic        accept;

  always_comb begin
    lo_sum = {1'b0, a_q[7:0]}  + {1'b0, b_q[7:0]}  + {8'd0, cin_q};
    hi_sum = {1'b0, a_q[15:8]} + {1'b0, b_q[15:8]} + {8'd0, c7_q};

    // Carry out of bit 11 is the carry into bit 12.
    // Recover it from the sum bit: s = a ^ b ^ carry_in.
    h_now  = a_q[12] ^ b_q[12] ^ hi_sum[4];
    c_now  = hi_sum[8];
    // Overflow is the carry into bit 15 XOR the carry out of bit 15.
    v_now  = (a_q[15] ^ b_q[15] ^ hi_sum[7]) ^ hi_sum[8];
  end

  always_comb begin
    // With LATENCY=2 the high pass completes on the same edge it is computed.
    // The live adder values must then be used instead of the registered ones.
    if (state_q == HI) begin
      hi_fin = hi_sum[7:0];
      h_fin  = h_now;
      c_fin  = c_now;
      v_fin  = v_now;
    end else begin
      hi_fin = hi_q;
      h_fin  = h_q;
      c_fin  = c_q;
      v_fin  = v_q;
    end
    r_fin = {hi_fin, lo_q};

    res_fin = r_fin;
    case (op_q)
      OP_ADD: flags_fin = {fin_q[7:5], h_fin, fin_q[3:2], 1'b0, c_fin};
      OP_ADC: flags_fin = {r_fin[15], (r_fin == 16'h0000), r_fin[13], h_fin,
                           r_fin[11], v_fin, 1'b0, c_fin};
      // The adder computed a + ~b + ~cin.
      // Its carries are therefore the complement of the borrows.
      OP_SBC: flags_fin = {r_fin[15], (r_fin == 16'h0000), r_fin[13], ~h_fin,
                           r_fin[11], v_fin, 1'b1, ~c_fin};
      default: begin
        flags_fin = fin_q;
        res_fin   = a_q;
      end
    endcase
  end

  always_comb begin
    if (LATENCY == 2) begin
      complete = (state_q == HI);
    end else begin
      complete = (state_q == PAD) && (cnt_q == LAT_CNT);
    end
    // The completion cycle also frees the unit, which allows back-to-back issue.
    accept = start && ((state_q == IDLE) || complete);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    fin_d     = fin_q;
    lo_d      = lo_q;
    c7_d      = c7_q;
    hi_d      = hi_q;
    h_d       = h_q;
    c_d       = c_q;
    v_d       = v_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    result_d  = result_q;
    fout_d    = fout_q;

    case (state_q)
      LO: begin
        lo_d    = lo_sum[7:0];
        c7_d    = lo_sum[8];
        cnt_d   = cnt_q + 4'd1;
        state_d = HI;
      end
      HI: begin
        hi_d    = hi_sum[7:0];
        h_d     = h_now;
        c_d     = c_now;
        v_d     = v_now;
        cnt_d   = cnt_q + 4'd1;
        state_d = PAD;
      end
      PAD: begin
        cnt_d   = cnt_q + 4'd1;
      end
      default: ;
    endcase

    if (complete) begin
      done_d    = 1'b1;
      illegal_d = (op_q == OP_ILL);
      result_d  = res_fin;
      fout_d    = flags_fin;
      busy_d    = 1'b0;
      cnt_d     = 4'd0;
      state_d   = IDLE;
    end

    if (accept) begin
      op_d    = op;
      a_d     = operand1;
      b_d     = (op == OP_SBC) ? ~operand2 : operand2;
      case (op)
        OP_ADC:  cin_d = f_in[0];
        OP_SBC:  cin_d = ~f_in[0];
        default: cin_d = 1'b0;
      endcase
      fin_d   = f_in;
      cnt_d   = 4'd1;
      busy_d  = 1'b1;
      state_d = LO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= OP_ADD;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      cin_q     <= 1'b0;
      fin_q     <= 8'h00;
      lo_q      <= 8'h00;
      c7_q      <= 1'b0;
      hi_q      <= 8'h00;
      h_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 16'h0000;
      fout_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      fin_q     <= fin_d;
      lo_q      <= lo_d;
      c7_q      <= c7_d;
      hi_q      <= hi_d;
      h_q       <= h_d;
      c_q       <= c_d;
      v_q       <= v_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      fout_q    <= fout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign result  = result_q;
  assign f_out   = fout_q;

endmodule

// File: tb/tb_z80_alu16_seq.sv
// ---------------------------------------------------------------------------
// tb_z80_alu16_seq
//
// Two instances share the same stimulus: LATENCY=7 (index 0) and LATENCY=2
// (index 1). A reference model computes each result with plain integer
// arithmetic and tracks completion by edge number. The bench compares every
// output of both instances on every cycle. Directed cases also check their
// literal expected results.
// ---------------------------------------------------------------------------
module tb_z80_alu16_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] operand1 = 16'h0000;
  logic [15:0] operand2 = 16'h0000;
  logic [7:0]  f_in = 8'h00;

  logic [1:0]  d_busy, d_done, d_ill;
  logic [15:0] d_res [2];
  logic [7:0]  d_f [2];

  z80_alu16_seq #(.LATENCY(7)) dut7 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2), .f_in(f_in),
    .busy(d_busy[0]), .done(d_done[0]), .illegal(d_ill[0]),
    .result(d_res[0]), .f_out(d_f[0])
  );

  z80_alu16_seq #(.LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2), .f_in(f_in),
    .busy(d_busy[1]), .done(d_done[1]), .illegal(d_ill[1]),
    .result(d_res[1]), .f_out(d_f[1])
  );

  // Reference arithmetic: returns {result, flags}.
  function automatic logic [23:0] golden(input logic [1:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [7:0] f);
    int unsigned ai, bi, ci, r;
    logic [15:0] rr;
    logic        hh, cc, vv;
    logic [7:0]  ff;
    ai = a;
    bi = b;
    ci = 0;
    rr = a;
    ff = f;
    case (o)
      2'b00: begin
        r  = ai + bi;
        rr = r[15:0];
        hh = ((ai & 32'hFFF) + (bi & 32'hFFF)) > 32'hFFF;
        cc = r > 32'hFFFF;
        ff = (f & 8'hEC) | {3'b000, hh, 3'b000, cc};
      end
      2'b01: begin
        ci = f[0];
        r  = ai + bi + ci;
        rr = r[15:0];
        hh = ((ai & 32'hFFF) + (bi & 32'hFFF) + ci) > 32'hFFF;
        cc = r > 32'hFFFF;
        vv = (a[15] == b[15]) && (rr[15] != a[15]);
        ff = {rr[15], rr == 16'h0000, rr[13], hh, rr[11], vv, 1'b0, cc};
      end
      2'b10: begin
        ci = f[0];
        rr = a - b - 16'(ci);
        hh = (ai & 32'hFFF) < ((bi & 32'hFFF) + ci);
        cc = ai < (bi + ci);
        vv = (a[15] != b[15]) && (rr[15] != a[15]);
        ff = {rr[15], rr == 16'h0000, rr[13], hh, rr[11], vv, 1'b1, cc};
      end
      default: ;
    endcase
    return {rr, ff};
  endfunction

  logic [23:0] gold;
  assign gold = golden(op, operand1, operand2, f_in);

  // Model: each instance has at most one pending operation.
  // The operation completes on edge number (accept edge + LATENCY).
  int          cyc = 0;
  int          due [2];
  logic        pend [2];
  logic [15:0] pend_res [2];
  logic [7:0]  pend_f [2];
  logic        pend_ill [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_ill [2];
  logic [15:0] m_res [2];
  logic [7:0]  m_f [2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        pend[i]   <= 1'b0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_ill[i]  <= 1'b0;
        m_res[i]  <= 16'h0000;
        m_f[i]    <= 8'h00;
      end else begin
        m_done[i] <= pend[i] && (cyc == due[i]);
        m_ill[i]  <= pend[i] && (cyc == due[i]) && pend_ill[i];
        if (pend[i] && (cyc == due[i])) begin
          m_res[i] <= pend_res[i];
          m_f[i]   <= pend_f[i];
        end
        if (start && (!pend[i] || (cyc == due[i]))) begin
          pend[i]     <= 1'b1;
          m_busy[i]   <= 1'b1;
          due[i]      <= cyc + ((i == 0) ? 7 : 2);
          pend_res[i] <= gold[23:8];
          pend_f[i]   <= gold[7:0];
          pend_ill[i] <= (op == 2'b11);
        end else if (pend[i] && (cyc == due[i])) begin
          pend[i]   <= 1'b0;
          m_busy[i] <= 1'b0;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock, then compare both instances against the model.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy[%0d]@%0d", i, cyc), 32'(d_busy[i]), 32'(m_busy[i]));
      chk($sformatf("done[%0d]@%0d", i, cyc), 32'(d_done[i]), 32'(m_done[i]));
      chk($sformatf("illegal[%0d]@%0d", i, cyc), 32'(d_ill[i]), 32'(m_ill[i]));
      chk($sformatf("result[%0d]@%0d", i, cyc), 32'(d_res[i]), 32'(m_res[i]));
      chk($sformatf("f_out[%0d]@%0d", i, cyc), 32'(d_f[i]), 32'(m_f[i]));
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] f);
    op = o;
    operand1 = a;
    operand2 = b;
    f_in = f;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Issue one operation and check the latency of both instances against literals.
  // Also check the values each instance shows at its done pulse.
  task automatic run_lit(input string name, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] f,
                         input logic [15:0] er, input logic [7:0] ef, input logic ei);
    int lat [2];
    logic [15:0] r [2];
    logic [7:0] fo [2];
    logic il [2];
    lat[0] = -1;
    lat[1] = -1;
    issue(o, a, b, f);
    for (int n = 1; n <= 20; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (d_done[i] && lat[i] < 0) begin
          lat[i] = n;
          r[i] = d_res[i];
          fo[i] = d_f[i];
          il[i] = d_ill[i];
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    chk({name, " latency L7"}, 32'(lat[0]), 32'd7);
    chk({name, " latency L2"}, 32'(lat[1]), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (lat[i] >= 0) begin
        chk($sformatf("%s result[%0d]", name, i), 32'(r[i]), 32'(er));
        chk($sformatf("%s f_out[%0d]", name, i), 32'(fo[i]), 32'(ef));
        chk($sformatf("%s illegal[%0d]", name, i), 32'(il[i]), 32'(ei));
      end
    end
    $display("%s: op=%0d a=%h b=%h f=%h -> L7 lat=%0d res=%h f=%h | L2 lat=%0d res=%h f=%h",
             name, o, a, b, f, lat[0], r[0], fo[0], lat[1], r[1], fo[1]);
  endtask

  initial begin
    int dn [2];

    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset busy[%0d]", i), 32'(d_busy[i]), 32'd0);
      chk($sformatf("reset done[%0d]", i), 32'(d_done[i]), 32'd0);
      chk($sformatf("reset result[%0d]", i), 32'(d_res[i]), 32'h0000);
      chk($sformatf("reset f_out[%0d]", i), 32'(d_f[i]), 32'h00);
    end
    reset = 1'b0;
    step();

    run_lit("ADD carry11", 2'b00, 16'h0FFF, 16'h0001, 8'hFF, 16'h1000, 8'hFC, 1'b0);
    run_lit("ADC wrap0",   2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51, 1'b0);
    run_lit("SBC ovf",     2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E, 1'b0);
    run_lit("ILLEGAL",     2'b11, 16'h1234, 16'h5678, 8'hA5, 16'h1234, 8'hA5, 1'b1);
    // Additional edge cases, hand-computed.
    // 7FFF+0+1 = 8000: S, H and PV set.
    run_lit("ADC ovf",     2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94, 1'b0);
    // 0-0-1 = FFFF: S, 5, H, 3, N and C set.
    run_lit("SBC borrow",  2'b10, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'hBB, 1'b0);
    // FFFF+1 = 0 for ADD: Z is preserved clear, H and C are set.
    run_lit("ADD wrap",    2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h11, 1'b0);

    // Back-to-back: start is held high for 21 edges.
    dn[0] = 0;
    dn[1] = 0;
    for (int c = 0; c < 21; c++) begin
      op = 2'(c % 3);
      operand1 = 16'(c * 16'h1357);
      operand2 = 16'(c * 16'h0F0F);
      f_in = 8'(c * 37);
      start = 1'b1;
      step();
      for (int i = 0; i < 2; i++) if (d_done[i]) dn[i]++;
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < 2; i++) if (d_done[i]) dn[i]++;
    end
    chk("b2b done count L7", 32'(dn[0]), 32'd3);
    chk("b2b done count L2", 32'(dn[1]), 32'd11);
    $display("back-to-back: L7 dones=%0d L2 dones=%0d", dn[0], dn[1]);

    // Reset in the middle of an operation.
    issue(2'b00, 16'h0FFF, 16'h0001, 8'hFF);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset busy[%0d]", i), 32'(d_busy[i]), 32'd0);
      chk($sformatf("midreset result[%0d]", i), 32'(d_res[i]), 32'h0000);
      chk($sformatf("midreset f_out[%0d]", i), 32'(d_f[i]), 32'h00);
    end
    dn[0] = 0;
    dn[1] = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      for (int i = 0; i < 2; i++) if (d_done[i]) dn[i]++;
    end
    chk("midreset no done L7", 32'(dn[0]), 32'd0);
    chk("midreset no done L2", 32'(dn[1]), 32'd0);
    $display("mid-op reset: dones after reset L7=%0d L2=%0d", dn[0], dn[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
